// File: rtl/prio_irq_queue.sv
// Prioritised interrupt queue: per-source request FSMs feed one FIFO per priority level,
// and the head of the highest non-empty level above cpu_pri is presented to the CPU.
module prio_irq_queue #(
   parameter int NUM_SRC = 8,
   parameter int PRI_W   = 3,
   parameter int DEPTH   = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_SRC-1:0]         irq_req,
   input  logic [NUM_SRC*PRI_W-1:0]   src_pri,
   input  logic [PRI_W-1:0]           cpu_pri,
   output logic [NUM_SRC-1:0]         irq_ack,
   output logic                       int_valid,
   output logic [$clog2(NUM_SRC)-1:0] int_src,
   output logic [PRI_W-1:0]           int_pri,
   input  logic                       int_take,
   output logic [(1<<PRI_W)-1:0]      lvl_full
);
   localparam int SRC_W   = $clog2(NUM_SRC);
   localparam int NUM_PRI = 1 << PRI_W;
   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = PTR_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_QUEUED, S_SERVICED} src_state_t;

   logic [PRI_W-1:0]   req_lvl  [NUM_SRC];
   logic [NUM_SRC-1:0] eligible;
   logic [SRC_W-1:0]   head_src [NUM_PRI];
   logic [NUM_PRI-1:0] lvl_busy;

   logic               grant_valid;
   logic [SRC_W-1:0]   grant_idx;
   logic [PRI_W-1:0]   grant_lvl;
   logic               top_found;
   logic [PRI_W-1:0]   top_lvl;
   logic               pop;

   genvar gi;

   // Lowest-index eligible source wins; scanning downward leaves the lowest index last.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      grant_lvl   = '0;
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
         if (eligible[k]) begin
            grant_valid = 1'b1;
            grant_idx   = SRC_W'(k);
            grant_lvl   = req_lvl[k];
         end
      end
   end

   always_comb begin
      top_found = 1'b0;
      top_lvl   = '0;
      for (int l = 0; l < NUM_PRI; l++) begin
         if (lvl_busy[l]) begin
            top_found = 1'b1;
            top_lvl   = PRI_W'(l);
         end
      end
   end

   assign int_valid = top_found && (top_lvl > cpu_pri);
   assign int_src   = int_valid ? head_src[top_lvl] : '0;
   assign int_pri   = int_valid ? top_lvl : '0;
   assign pop       = int_take && int_valid;

   generate
      for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
         src_state_t state_reg;
         logic       ack_reg;
         logic       won;

         assign req_lvl[gi]  = src_pri[gi*PRI_W +: PRI_W];
         assign eligible[gi] = (state_reg == S_IDLE) && irq_req[gi] && !lvl_full[req_lvl[gi]];
         assign won          = grant_valid && (grant_idx == SRC_W'(gi));
         assign irq_ack[gi]  = ack_reg;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               state_reg <= S_IDLE;
               ack_reg   <= 1'b0;
            end else begin
               ack_reg <= won;
               case (state_reg)
                  S_IDLE:     if (won) state_reg <= S_QUEUED;
                  S_QUEUED:   if (pop && (int_src == SRC_W'(gi))) state_reg <= S_SERVICED;
                  // A request still held after service must drop before it can queue again.
                  S_SERVICED: if (!irq_req[gi]) state_reg <= S_IDLE;
                  default:    state_reg <= S_IDLE;
               endcase
            end
         end
      end

      for (gi = 0; gi < NUM_PRI; gi++) begin : g_lvl
         logic [SRC_W-1:0] mem [DEPTH];
         logic [PTR_W-1:0] rd_ptr_reg;
         logic [PTR_W-1:0] wr_ptr_reg;
         logic [CNT_W-1:0] count_reg;
         logic             push_en;
         logic             pop_en;

         assign push_en      = grant_valid && (grant_lvl == PRI_W'(gi));
         assign pop_en       = pop && (top_lvl == PRI_W'(gi));
         assign lvl_full[gi] = (count_reg == CNT_W'(DEPTH));
         assign lvl_busy[gi] = (count_reg != '0);
         assign head_src[gi] = mem[rd_ptr_reg];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rd_ptr_reg <= '0;
               wr_ptr_reg <= '0;
               count_reg  <= '0;
            end else begin
               if (push_en) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
               if (pop_en)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
               case ({push_en, pop_en})
                  2'b10:   count_reg <= count_reg + CNT_W'(1);
                  2'b01:   count_reg <= count_reg - CNT_W'(1);
                  default: count_reg <= count_reg;
               endcase
            end
         end

         // Entry storage carries no reset; only the pointers and count define validity.
         always_ff @(posedge clk) begin
            if (push_en) mem[wr_ptr_reg] <= grant_idx;
         end
      end
   endgenerate
endmodule

// File: tb/tb_prio_irq_queue.sv
// Directed scenarios plus randomized traffic checked against a queue-based model
// of the interrupt controller.
module tb_prio_irq_queue;
   localparam int NUM_SRC = 8;
   localparam int PRI_W   = 3;
   localparam int DEPTH   = 4;
   localparam int NUM_PRI = 8;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic [NUM_SRC-1:0]       irq_req;
   logic [NUM_SRC*PRI_W-1:0] src_pri;
   logic [PRI_W-1:0]         cpu_pri;
   logic [NUM_SRC-1:0]       irq_ack;
   logic                     int_valid;
   logic [2:0]               int_src;
   logic [PRI_W-1:0]         int_pri;
   logic                     int_take;
   logic [NUM_PRI-1:0]       lvl_full;

   always #5 clk = ~clk;

   prio_irq_queue #(.NUM_SRC(NUM_SRC), .PRI_W(PRI_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .irq_req(irq_req), .src_pri(src_pri), .cpu_pri(cpu_pri),
      .irq_ack(irq_ack), .int_valid(int_valid), .int_src(int_src), .int_pri(int_pri),
      .int_take(int_take), .lvl_full(lvl_full)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: one arrival-ordered list of (source, level) entries.
   int                 ent_src[$];
   int                 ent_lvl[$];
   bit                 in_q   [NUM_SRC];
   bit                 served [NUM_SRC];
   logic [NUM_SRC-1:0] exp_ack;

   function automatic int pri_of(int k);
      return int'((src_pri >> (k * PRI_W)) & 24'h7);
   endfunction

   function automatic int lvl_count(int l);
      int n = 0;
      for (int i = 0; i < ent_lvl.size(); i++) if (ent_lvl[i] == l) n++;
      return n;
   endfunction

   function automatic int top_level();
      int t = -1;
      for (int l = 0; l < NUM_PRI; l++) if (lvl_count(l) > 0) t = l;
      return t;
   endfunction

   function automatic bit exp_valid();
      int t = top_level();
      return (t >= 0) && (t > int'(cpu_pri));
   endfunction

   function automatic int exp_src();
      int t = top_level();
      if (!exp_valid()) return 0;
      for (int i = 0; i < ent_lvl.size(); i++) if (ent_lvl[i] == t) return ent_src[i];
      return 0;
   endfunction

   function automatic int exp_pri();
      return exp_valid() ? top_level() : 0;
   endfunction

   function automatic logic [NUM_PRI-1:0] exp_full();
      logic [NUM_PRI-1:0] f = '0;
      for (int l = 0; l < NUM_PRI; l++) f[l] = (lvl_count(l) == DEPTH);
      return f;
   endfunction

   task automatic model_reset();
      ent_src.delete();
      ent_lvl.delete();
      for (int k = 0; k < NUM_SRC; k++) begin
         in_q[k]   = 1'b0;
         served[k] = 1'b0;
      end
      exp_ack = '0;
   endtask

   task automatic model_advance();
      int g;
      int t;
      int s;
      bit v;
      g = -1;
      v = exp_valid();
      s = exp_src();
      t = top_level();
      for (int k = 0; k < NUM_SRC; k++)
         if (g < 0 && irq_req[k] && !in_q[k] && !served[k] && lvl_count(pri_of(k)) < DEPTH) g = k;
      for (int k = 0; k < NUM_SRC; k++)
         if (served[k] && !irq_req[k]) served[k] = 1'b0;
      if (int_take === 1'b1 && v) begin
         for (int i = 0; i < ent_lvl.size(); i++) begin
            if (ent_lvl[i] == t) begin
               ent_lvl.delete(i);
               ent_src.delete(i);
               break;
            end
         end
         in_q[s]   = 1'b0;
         served[s] = 1'b1;
      end
      if (g >= 0) begin
         ent_src.push_back(g);
         ent_lvl.push_back(pri_of(g));
         in_q[g] = 1'b1;
      end
      exp_ack = (g >= 0) ? NUM_SRC'(1 << g) : '0;
   endtask

   task automatic tick();
      if (!rst_n) model_reset();
      else model_advance();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_pri(input int k, input int p);
      src_pri[k*PRI_W +: PRI_W] = PRI_W'(p);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; irq_req = '0; src_pri = '0; cpu_pri = '0; int_take = 1'b0;
      model_reset();
      @(negedge clk);
      tick();
      checks++; if (irq_ack !== 8'h00) begin errors++; $display("FAIL rst_ack got %h exp 00", irq_ack); end
      checks++; if (int_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", int_valid); end
      checks++; if (int_src !== 3'd0) begin errors++; $display("FAIL rst_src got %0d exp 0", int_src); end
      checks++; if (int_pri !== 3'd0) begin errors++; $display("FAIL rst_pri got %0d exp 0", int_pri); end
      checks++; if (lvl_full !== 8'h00) begin errors++; $display("FAIL rst_full got %h exp 00", lvl_full); end
      rst_n = 1'b1;
      tick();
      $display("test_reset done");
   endtask

   task automatic test_basic();
      cpu_pri = '0; set_pri(2, 5); irq_req = 8'h04; #1;
      checks++; if (int_valid !== 1'b0) begin errors++; $display("FAIL basic_pre_valid got %b exp 0", int_valid); end
      tick();
      checks++; if (irq_ack !== 8'h04) begin errors++; $display("FAIL basic_ack got %h exp 04", irq_ack); end
      checks++; if (int_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", int_valid); end
      checks++; if (int_src !== 3'd2) begin errors++; $display("FAIL basic_src got %0d exp 2", int_src); end
      checks++; if (int_pri !== 3'd5) begin errors++; $display("FAIL basic_pri got %0d exp 5", int_pri); end
      int_take = 1'b1; tick(); int_take = 1'b0;
      checks++; if (int_valid !== 1'b0) begin errors++; $display("FAIL basic_taken_valid got %b exp 0", int_valid); end
      checks++; if (irq_ack !== 8'h00) begin errors++; $display("FAIL basic_ack_pulse got %h exp 00", irq_ack); end
      irq_req = '0; tick(); tick();
      $display("test_basic done");
   endtask

   task automatic test_arbitration();
      set_pri(1, 3); set_pri(6, 6); cpu_pri = '0; irq_req = 8'h42;
      tick();
      checks++; if (irq_ack !== 8'h02) begin errors++; $display("FAIL arb_ack1 got %h exp 02", irq_ack); end
      checks++; if (int_src !== 3'd1) begin errors++; $display("FAIL arb_src1 got %0d exp 1", int_src); end
      tick();
      checks++; if (irq_ack !== 8'h40) begin errors++; $display("FAIL arb_ack6 got %h exp 40", irq_ack); end
      checks++; if (int_src !== 3'd6) begin errors++; $display("FAIL arb_src6 got %0d exp 6", int_src); end
      checks++; if (int_pri !== 3'd6) begin errors++; $display("FAIL arb_pri6 got %0d exp 6", int_pri); end
      int_take = 1'b1; tick();
      checks++; if (int_src !== 3'd1) begin errors++; $display("FAIL arb_next_src got %0d exp 1", int_src); end
      checks++; if (int_pri !== 3'd3) begin errors++; $display("FAIL arb_next_pri got %0d exp 3", int_pri); end
      tick(); int_take = 1'b0;
      checks++; if (int_valid !== 1'b0) begin errors++; $display("FAIL arb_drained got %b exp 0", int_valid); end
      irq_req = '0; tick(); tick();
      $display("test_arbitration done");
   endtask

   task automatic test_fifo_full();
      logic [7:0] e;
      for (int k = 0; k < 5; k++) set_pri(k, 4);
      cpu_pri = '0; irq_req = 8'h1F;
      for (int i = 0; i < 4; i++) begin
         tick();
         e = 8'(1 << i);
         checks++; if (irq_ack !== e) begin errors++; $display("FAIL full_ack%0d got %h exp %h", i, irq_ack, e); end
      end
      checks++; if (lvl_full !== 8'h10) begin errors++; $display("FAIL full_flag got %h exp 10", lvl_full); end
      tick();
      checks++; if (irq_ack !== 8'h00) begin errors++; $display("FAIL full_blocked got %h exp 00", irq_ack); end
      checks++; if (int_src !== 3'd0) begin errors++; $display("FAIL full_head got %0d exp 0", int_src); end
      int_take = 1'b1; tick(); int_take = 1'b0;
      checks++; if (irq_ack !== 8'h00) begin errors++; $display("FAIL full_same_edge got %h exp 00", irq_ack); end
      checks++; if (lvl_full !== 8'h00) begin errors++; $display("FAIL full_freed got %h exp 00", lvl_full); end
      tick();
      checks++; if (irq_ack !== 8'h10) begin errors++; $display("FAIL full_late_ack got %h exp 10", irq_ack); end
      int_take = 1'b1;
      for (int i = 1; i < 5; i++) begin
         checks++; if (int_src !== 3'(i)) begin errors++; $display("FAIL fifo_order got %0d exp %0d", int_src, i); end
         tick();
      end
      int_take = 1'b0;
      checks++; if (int_valid !== 1'b0) begin errors++; $display("FAIL full_drained got %b exp 0", int_valid); end
      irq_req = '0; tick(); tick();
      $display("test_fifo_full done");
   endtask

   task automatic test_mask();
      set_pri(3, 2); cpu_pri = 3'd2; irq_req = 8'h08;
      tick();
      checks++; if (irq_ack !== 8'h08) begin errors++; $display("FAIL mask_ack got %h exp 08", irq_ack); end
      checks++; if (int_valid !== 1'b0) begin errors++; $display("FAIL mask_valid got %b exp 0", int_valid); end
      checks++; if (int_src !== 3'd0) begin errors++; $display("FAIL mask_src got %0d exp 0", int_src); end
      cpu_pri = 3'd1; #1;
      checks++; if (int_valid !== 1'b1) begin errors++; $display("FAIL unmask_valid got %b exp 1", int_valid); end
      checks++; if (int_src !== 3'd3) begin errors++; $display("FAIL unmask_src got %0d exp 3", int_src); end
      checks++; if (int_pri !== 3'd2) begin errors++; $display("FAIL unmask_pri got %0d exp 2", int_pri); end
      cpu_pri = 3'd7; #1;
      checks++; if (int_valid !== 1'b0) begin errors++; $display("FAIL remask_valid got %b exp 0", int_valid); end
      cpu_pri = '0; int_take = 1'b1; tick(); int_take = 1'b0;
      irq_req = '0; tick(); tick();
      $display("test_mask done");
   endtask

   task automatic test_rereq();
      set_pri(4, 7); cpu_pri = '0; irq_req = 8'h10;
      tick();
      checks++; if (irq_ack !== 8'h10) begin errors++; $display("FAIL rereq_ack1 got %h exp 10", irq_ack); end
      int_take = 1'b1; tick(); int_take = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (irq_ack !== 8'h00 || int_valid !== 1'b0) begin errors++; $display("FAIL rereq_held got ack %h valid %b exp 00/0", irq_ack, int_valid); end
      end
      irq_req = '0; tick();
      irq_req = 8'h10; tick();
      checks++; if (irq_ack !== 8'h10) begin errors++; $display("FAIL rereq_ack2 got %h exp 10", irq_ack); end
      checks++; if (int_src !== 3'd4 || int_pri !== 3'd7) begin errors++; $display("FAIL rereq_entry got %0d/%0d exp 4/7", int_src, int_pri); end
      int_take = 1'b1; tick(); int_take = 1'b0;
      irq_req = '0; tick(); tick();
      $display("test_rereq done");
   endtask

   task automatic test_reset_mid();
      set_pri(0, 1); set_pri(1, 2); set_pri(2, 3); cpu_pri = '0; irq_req = 8'h07;
      tick(); tick(); tick();
      checks++; if (int_valid !== 1'b1 || int_src !== 3'd2) begin errors++; $display("FAIL mid_pre got valid %b src %0d exp 1/2", int_valid, int_src); end
      rst_n = 1'b0; irq_req = '0; #1;
      checks++; if (irq_ack !== 8'h00) begin errors++; $display("FAIL mid_ack got %h exp 00", irq_ack); end
      checks++; if (int_valid !== 1'b0 || int_src !== 3'd0 || int_pri !== 3'd0) begin errors++; $display("FAIL mid_out got %b/%0d/%0d exp 0/0/0", int_valid, int_src, int_pri); end
      checks++; if (lvl_full !== 8'h00) begin errors++; $display("FAIL mid_full got %h exp 00", lvl_full); end
      tick(); tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (int_valid !== 1'b0 || irq_ack !== 8'h00) begin errors++; $display("FAIL mid_stale got valid %b ack %h exp 0/00", int_valid, irq_ack); end
      end
      $display("test_reset_mid done");
   endtask

   task automatic test_random();
      logic [NUM_SRC-1:0] e_ack;
      logic [NUM_PRI-1:0] e_full;
      bit                 e_valid;
      logic [2:0]         e_src;
      logic [2:0]         e_pri;
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < NUM_SRC; k++) if ($urandom_range(0, 9) == 0) irq_req[k] = ~irq_req[k];
         if ($urandom_range(0, 7) == 0)
            set_pri(int'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(1, 3)));
         if ($urandom_range(0, 15) == 0) cpu_pri = ($urandom_range(0, 1) == 1) ? 3'd0 : 3'($urandom_range(0, 7));
         int_take = ($urandom_range(0, 2) == 0);
         if (c % 700 == 699) rst_n = 1'b0;
         #1;
         e_ack = exp_ack; e_full = exp_full(); e_valid = exp_valid();
         e_src = 3'(exp_src()); e_pri = 3'(exp_pri());
         if (!rst_n) begin
            e_ack = '0; e_full = '0; e_valid = 1'b0; e_src = '0; e_pri = '0;
         end
         checks++; if (irq_ack !== e_ack) begin errors++; $display("FAIL rnd_ack cyc %0d got %h exp %h", c, irq_ack, e_ack); end
         checks++; if (int_valid !== e_valid) begin errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", c, int_valid, e_valid); end
         checks++; if (int_src !== e_src) begin errors++; $display("FAIL rnd_src cyc %0d got %0d exp %0d", c, int_src, e_src); end
         checks++; if (int_pri !== e_pri) begin errors++; $display("FAIL rnd_pri cyc %0d got %0d exp %0d", c, int_pri, e_pri); end
         checks++; if (lvl_full !== e_full) begin errors++; $display("FAIL rnd_full cyc %0d got %h exp %h", c, lvl_full, e_full); end
         tick();
         if (!rst_n) rst_n = 1'b1;
      end
      int_take = 1'b0; irq_req = '0;
      $display("test_random done");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_arbitration();
      test_fifo_full();
      test_mask();
      test_rereq();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
